core_alu_reg: RTL and testbench



---
 rtl/core_alu_reg.sv | 149 ++++++++++++++
 tb/tb_core_alu_reg.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_alu_reg.sv
// rtl/core_alu_reg.sv - 8-bit 6502-style ALU with clock-enabled result/flag register
// Combinational result and C/Z/V/N feed the core directly; the register keeps the last enabled copy.
module core_alu_reg (
    input  logic       I_clock,
    input  logic       I_reset,
    input  logic       I_enable,
    input  logic [3:0] I_control,
    input  logic [7:0] I_lhs,
    input  logic [7:0] I_rhs,
    input  logic       I_carry,
    input  logic       I_overflow,
    input  logic       I_sign,
    input  logic       I_zero,
    output logic [7:0] O_result,
    output logic       O_carry,
    output logic       O_overflow,
    output logic       O_sign,
    output logic       O_zero,
    output logic [7:0] O_q_result,
    output logic [3:0] O_q_flags
);

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LOAD = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_ORA  = 4'd3;
    localparam logic [3:0] OP_EOR  = 4'd4;
    localparam logic [3:0] OP_ADC  = 4'd5;
    localparam logic [3:0] OP_SBC  = 4'd6;
    localparam logic [3:0] OP_CMP  = 4'd7;
    localparam logic [3:0] OP_ASL  = 4'd8;
    localparam logic [3:0] OP_LSR  = 4'd9;
    localparam logic [3:0] OP_ROL  = 4'd10;
    localparam logic [3:0] OP_ROR  = 4'd11;
    localparam logic [3:0] OP_INC  = 4'd12;
    localparam logic [3:0] OP_DEC  = 4'd13;
    localparam logic [3:0] OP_BIT  = 4'd14;
    localparam logic [3:0] OP_TRN  = 4'd15;

    logic [7:0] rhs_add;
    logic [8:0] sum9;
    logic [8:0] cmp9;
    logic [7:0] result;
    logic       carry;
    logic       overflow;
    logic       sign;
    logic       zero;
    logic       set_nz;

    logic [7:0] q_result_q;
    logic [7:0] q_result_d;
    logic [3:0] q_flags_q;
    logic [3:0] q_flags_d;

    // ADC and SBC share one adder: SBC adds the one's complement with C as the not-borrow
    always_comb begin
        rhs_add = (I_control == OP_SBC) ? ~I_rhs : I_rhs;
        sum9    = {1'b0, I_lhs} + {1'b0, rhs_add} + {8'd0, I_carry};
        cmp9    = {1'b0, I_lhs} + {1'b0, ~I_rhs} + 9'd1;
    end

    always_comb begin
        result   = I_lhs;
        carry    = I_carry;
        overflow = I_overflow;
        sign     = I_sign;
        zero     = I_zero;
        set_nz   = 1'b1;
        case (I_control)
            OP_NOP: begin
                set_nz = 1'b0;
            end
            OP_LOAD: result = I_rhs;
            OP_AND:  result = I_lhs & I_rhs;
            OP_ORA:  result = I_lhs | I_rhs;
            OP_EOR:  result = I_lhs ^ I_rhs;
            OP_ADC, OP_SBC: begin
                result   = sum9[7:0];
                carry    = sum9[8];
                overflow = (I_lhs[7] == rhs_add[7]) && (sum9[7] != I_lhs[7]);
            end
            OP_CMP: begin
                set_nz = 1'b0;
                carry  = cmp9[8];
                zero   = (cmp9[7:0] == 8'h00);
                sign   = cmp9[7];
            end
            OP_ASL: begin
                result = {I_lhs[6:0], 1'b0};
                carry  = I_lhs[7];
            end
            OP_LSR: begin
                result = {1'b0, I_lhs[7:1]};
                carry  = I_lhs[0];
            end
            OP_ROL: begin
                result = {I_lhs[6:0], I_carry};
                carry  = I_lhs[7];
            end
            OP_ROR: begin
                result = {I_carry, I_lhs[7:1]};
                carry  = I_lhs[0];
            end
            OP_INC: result = I_lhs + 8'd1;
            OP_DEC: result = I_lhs - 8'd1;
            OP_BIT: begin
                set_nz   = 1'b0;
                zero     = ((I_lhs & I_rhs) == 8'h00);
                sign     = I_rhs[7];
                overflow = I_rhs[6];
            end
            OP_TRN: result = I_rhs;
            default: set_nz = 1'b0;
        endcase
        if (set_nz) begin
            sign = result[7];
            zero = (result == 8'h00);
        end
    end

    assign O_result   = result;
    assign O_carry    = carry;
    assign O_overflow = overflow;
    assign O_sign     = sign;
    assign O_zero     = zero;

    always_comb begin
        q_result_d = q_result_q;
        q_flags_d  = q_flags_q;
        if (I_enable) begin
            q_result_d = result;
            q_flags_d  = {sign, overflow, zero, carry};
        end
    end

    always_ff @(posedge I_clock) begin
        if (!I_reset) begin
            q_result_q <= 8'h00;
            q_flags_q  <= 4'h0;
        end else begin
            q_result_q <= q_result_d;
            q_flags_q  <= q_flags_d;
        end
    end

    assign O_q_result = q_result_q;
    assign O_q_flags  = q_flags_q;

endmodule

// File: tb/tb_core_alu_reg.sv
// tb/tb_core_alu_reg.sv - self-checking bench for core_alu_reg
// Directed boundary vectors plus randomized ops against an integer-arithmetic reference model.
module tb_core_alu_reg;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] ctl;
    logic [7:0] lhs;
    logic [7:0] rhs;
    logic       cin, vin, nin, zin;
    logic [7:0] res;
    logic       cout, vout, nout, zout;
    logic [7:0] q_res;
    logic [3:0] q_flags;

    int checks;
    int failures;

    core_alu_reg dut (
        .I_clock    (clk),
        .I_reset    (rst_n),
        .I_enable   (en),
        .I_control  (ctl),
        .I_lhs      (lhs),
        .I_rhs      (rhs),
        .I_carry    (cin),
        .I_overflow (vin),
        .I_sign     (nin),
        .I_zero     (zin),
        .O_result   (res),
        .O_carry    (cout),
        .O_overflow (vout),
        .O_sign     (nout),
        .O_zero     (zout),
        .O_q_result (q_res),
        .O_q_flags  (q_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sx(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    // Returns {result[7:0], N, V, Z, C} computed with plain integer arithmetic
    function automatic logic [11:0] model(input int op, input int a, input int b,
                                          input int c, input int v, input int n, input int z);
        int  r, s, sa;
        int  cc, vv, nn, zz;
        bit  nz;
        logic [7:0] r8;
        cc = c; vv = v; nn = n; zz = z; nz = 1; r = a;
        case (op)
            0: nz = 0;
            1: r = b;
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin
                s  = a + b + c;
                r  = s % 256;
                cc = (s > 255);
                sa = sx(a) + sx(b) + c;
                vv = (sa > 127 || sa < -128);
            end
            6: begin
                s  = a - b - (1 - c);
                r  = (s + 256) % 256;
                cc = (s >= 0);
                sa = sx(a) - sx(b) - (1 - c);
                vv = (sa > 127 || sa < -128);
            end
            7: begin
                nz = 0;
                cc = (a >= b);
                zz = (a == b);
                nn = (((a - b + 256) % 256) >= 128);
            end
            8:  begin r = (a * 2) % 256;         cc = (a >= 128); end
            9:  begin r = a / 2;                 cc = a % 2;      end
            10: begin r = (a * 2) % 256 + c;     cc = (a >= 128); end
            11: begin r = a / 2 + c * 128;       cc = a % 2;      end
            12: r = (a + 1) % 256;
            13: r = (a + 255) % 256;
            14: begin
                nz = 0;
                zz = ((a & b) == 0);
                nn = (b >= 128);
                vv = (b / 64) % 2;
            end
            default: r = b;
        endcase
        if (nz) begin
            nn = (r >= 128);
            zz = (r == 0);
        end
        r8 = r[7:0];
        return {r8, nn[0], vv[0], zz[0], cc[0]};
    endfunction

    task automatic drive(input int op, input int a, input int b,
                         input int c, input int v, input int n, input int z);
        ctl = op[3:0];
        lhs = a[7:0];
        rhs = b[7:0];
        cin = c[0];
        vin = v[0];
        nin = n[0];
        zin = z[0];
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b1; en = 1'b1;
        drive(1, 0, 8'hFF, 1, 1, 0, 0);
        @(posedge clk); #1;
        checks++;
        if (q_res !== 8'hFF || q_flags !== 4'b1101) begin
            failures++;
            $display("FAIL preload q_result=%h q_flags=%b expected ff 1101", q_res, q_flags);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (q_res !== 8'h00 || q_flags !== 4'h0) begin
            failures++;
            $display("FAIL reset_clear q_result=%h q_flags=%b expected 00 0000", q_res, q_flags);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(5, 1, 1, 0, 0, 0, 0);
        #1;
        checks++;
        if (q_res !== 8'h00 || res !== 8'h02) begin
            failures++;
            $display("FAIL latency_before q_result=%h result=%h expected 00 02", q_res, res);
        end
        @(posedge clk); #1;
        checks++;
        if (q_res !== 8'h02 || q_flags !== 4'h0) begin
            failures++;
            $display("FAIL adc_after_reset q_result=%h q_flags=%b expected 02 0000", q_res, q_flags);
        end
    endtask

    typedef struct {
        int         op, a, b, c, v, n, z;
        logic [7:0] exp_res;
        logic [3:0] exp_flags;
    } vec_t;

    task automatic test_directed;
        vec_t vecs[16];
        vecs[0]  = '{5,  'h7F, 'h01, 0, 0, 0, 1, 8'h80, 4'b1100};
        vecs[1]  = '{5,  'hFF, 'h01, 0, 1, 0, 0, 8'h00, 4'b0011};
        vecs[2]  = '{6,  'h50, 'hF0, 1, 0, 0, 0, 8'h60, 4'b0000};
        vecs[3]  = '{6,  'h80, 'h01, 1, 0, 0, 0, 8'h7F, 4'b0101};
        vecs[4]  = '{7,  'h10, 'h10, 0, 1, 1, 0, 8'h10, 4'b0111};
        vecs[5]  = '{7,  'h10, 'h20, 1, 0, 0, 1, 8'h10, 4'b1000};
        vecs[6]  = '{10, 'h80, 'h00, 1, 0, 0, 0, 8'h01, 4'b0001};
        vecs[7]  = '{11, 'h01, 'h00, 1, 0, 0, 0, 8'h80, 4'b1001};
        vecs[8]  = '{9,  'h01, 'h00, 1, 0, 1, 0, 8'h00, 4'b0011};
        vecs[9]  = '{8,  'h40, 'h00, 1, 0, 0, 1, 8'h80, 4'b1000};
        vecs[10] = '{14, 'h0F, 'hC0, 1, 0, 0, 0, 8'h0F, 4'b1111};
        vecs[11] = '{12, 'hFF, 'h00, 1, 0, 1, 0, 8'h00, 4'b0011};
        vecs[12] = '{13, 'h00, 'h00, 0, 1, 0, 1, 8'hFF, 4'b1100};
        vecs[13] = '{0,  'hA5, 'h3C, 0, 0, 1, 1, 8'hA5, 4'b1010};
        vecs[14] = '{1,  'h77, 'h00, 1, 1, 1, 0, 8'h00, 4'b0111};
        vecs[15] = '{15, 'h00, 'h80, 0, 0, 0, 1, 8'h80, 4'b1000};
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            en = 1'b1;
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].v, vecs[i].n, vecs[i].z);
            #1;
            checks++;
            if (res !== vecs[i].exp_res || {nout, vout, zout, cout} !== vecs[i].exp_flags) begin
                failures++;
                $display("FAIL directed[%0d] op=%0d result=%h nvzc=%b expected %h %b", i, vecs[i].op,
                         res, {nout, vout, zout, cout}, vecs[i].exp_res, vecs[i].exp_flags);
            end
            @(posedge clk); #1;
            checks++;
            if (q_res !== vecs[i].exp_res || q_flags !== vecs[i].exp_flags) begin
                failures++;
                $display("FAIL directed_reg[%0d] q_result=%h q_flags=%b expected %h %b", i,
                         q_res, q_flags, vecs[i].exp_res, vecs[i].exp_flags);
            end
        end
    endtask

    task automatic test_enable_hold;
        logic [7:0] held_res;
        logic [3:0] held_flags;
        @(negedge clk);
        en = 1'b1;
        drive(4, 'hC3, 'h0F, 1, 1, 0, 0);
        @(posedge clk); #1;
        held_res   = 8'hCC;
        held_flags = 4'b1101;
        checks++;
        if (q_res !== held_res || q_flags !== held_flags) begin
            failures++;
            $display("FAIL hold_load q_result=%h q_flags=%b expected %h %b", q_res, q_flags, held_res, held_flags);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            en = 1'b0;
            drive($urandom_range(15), $urandom_range(255), $urandom_range(255),
                  $urandom_range(1), $urandom_range(1), $urandom_range(1), $urandom_range(1));
            @(posedge clk); #1;
            checks++;
            if (q_res !== held_res || q_flags !== held_flags) begin
                failures++;
                $display("FAIL hold[%0d] q_result=%h q_flags=%b expected %h %b", i,
                         q_res, q_flags, held_res, held_flags);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [11:0] exp;
        logic [7:0]  sb_res;
        logic [3:0]  sb_flags;
        int op, a, b, c, v, n, z;
        sb_res   = q_res;
        sb_flags = q_flags;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            op = $urandom_range(15);
            a  = $urandom_range(255);
            b  = $urandom_range(255);
            c  = $urandom_range(1);
            v  = $urandom_range(1);
            n  = $urandom_range(1);
            z  = $urandom_range(1);
            en = ($urandom_range(3) != 0);
            drive(op, a, b, c, v, n, z);
            exp = model(op, a, b, c, v, n, z);
            #1;
            checks++;
            if (res !== exp[11:4] || {nout, vout, zout, cout} !== exp[3:0]) begin
                failures++;
                $display("FAIL random_comb[%0d] op=%0d a=%h b=%h result=%h nvzc=%b expected %h %b", i, op,
                         a, b, res, {nout, vout, zout, cout}, exp[11:4], exp[3:0]);
            end
            if (en) begin
                sb_res   = exp[11:4];
                sb_flags = exp[3:0];
            end
            @(posedge clk); #1;
            checks++;
            if (q_res !== sb_res || q_flags !== sb_flags) begin
                failures++;
                $display("FAIL random_reg[%0d] q_result=%h q_flags=%b expected %h %b", i,
                         q_res, q_flags, sb_res, sb_flags);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        en       = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        test_reset;
        test_directed;
        test_enable_hold;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
